shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Multi-cycle shift unit controller for the processor's shift path: accepts one shift operation (logical left or arithmetic right, 5-bit amount) over a valid/ready handshake and runs it as five conditional power-of-two stages (16, 8, 4, 2, 1), one stage per clock. The datapath is shared across cycles, so it needs only one stage's worth of muxing. It sits beside the ALU and serves the sll/sra opcodes whenever the single-cycle barrel path is not used. Results return over a second valid/ready handshake with backpressure.

## Interface
- Parameters: none; data width fixed at 32, shift amount at 5.
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request (high only in IDLE).
- in_data  in  32  operand.
- in_shamt  in  5  shift amount, 0–31.
- in_op  in  1  0 = logical left (sll), 1 = arithmetic right (sra).
- out_valid  out  1  result available (high only in DONE).
- out_ready  in  1  consumer takes result.
- out_data  out  32  result; driven directly from the accumulator register.
- busy  out  1  high in SHIFT or DONE.

## Operation
- State register values: IDLE, SHIFT, DONE. Internal registers:
  - acc[31:0]
  - amt[4:0]
  - op
  - stage[2:0]
- IDLE:
  - in_ready = 1.
  - On in_valid: acc ← in_data, amt ← in_shamt, op ← in_op, stage ← 4, go to SHIFT.
  - Inputs are ignored in all other states.
- SHIFT, one edge per stage:
  - If amt[stage] = 1, apply the shift by 2^stage to acc; otherwise acc is unchanged.
  - sll fills vacated low bits with 0.
  - sra fills vacated high bits with acc[31] as it stands in that cycle. The sign is preserved, because every stage copies bit 31.
  - If stage = 0, go to DONE; otherwise stage ← stage − 1.
- DONE:
  - out_valid = 1; out_data = acc, held stable.
  - On out_ready, go to IDLE.
  - acc is left unchanged, so out_data keeps the last result while IDLE.
- Shift amount 0: still takes all five stages; result = in_data.
- Shift amount 31 with sra: result is all copies of the sign bit.
- Only amt bits select stages; there are no out-of-range amounts.
- Reset:
  - All outputs and state clear: state = IDLE, acc = 0, amt = 0, op = 0, stage = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
  - Reset during SHIFT or DONE abandons the operation with no result emitted.
  - Reset takes priority over every handshake in the same cycle.

## Timing
- Acceptance edge T0: in_valid & in_ready sampled high.
- SHIFT stages execute on edges T1 (stage 16) through T5 (stage 1).
- out_valid rises after T5, i.e. 5 cycles of latency from the acceptance edge. Latency is independent of amount and op.
- Result consumed on the first edge Tn (n ≥ 6) where out_ready = 1; in_ready is high again after that edge.
- No accept in the same cycle as the result handshake. Minimum spacing between acceptances is 7 edges (T0 → T7).
- in_ready and out_valid are combinational decodes of state only. No input-to-output combinational path exists.

## Test plan
- After reset, check in_ready = 1, out_valid = 0, out_data = 0, busy = 0. Then accept sra, 0x80000000, amount 8 → out_valid rises exactly 5 edges after accept with out_data = 0xFF800000.
- sll, 0x00000001, amount 31 → 0x80000000. Then sll, 0xDEADBEEF, amount 0 → 0xDEADBEEF. Both with 5-cycle latency.
- sra, 0x7FFFFFFF, amount 31 → 0x00000000. Then sra, 0xF0000000, amount 31 → 0xFFFFFFFF. Then sra, 0x12345678, amount 4 → 0x01234567.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → out_valid and out_data stay constant and in_ready stays 0. Meanwhile present a new in_valid, which is ignored. Raise out_ready → in_ready = 1 on the next cycle.
- Reset mid-operation: assert reset on the edge after T2 → next cycle state = IDLE, out_valid = 0, out_data = 0. No result is ever emitted for the abandoned request. A following request completes normally.
- Back-to-back requests with in_valid held high and out_ready held high → acceptances are exactly 7 edges apart, results arrive in order, and each matches the reference sll/sra value.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle for the multi-cycle shift unit.
//   master : requester side (drives request and out_ready, sees results)
//   slave  : shift unit side
//   in_valid/in_ready/in_data/in_shamt/in_op : request channel
//   out_valid/out_ready/out_data            : result channel
//   busy                                    : operation in flight or result pending
interface shift_sequencer_if;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic               in_op;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               busy;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: sll / sra of a 32-bit operand by a 5-bit amount,
// executed as five conditional power-of-two stages (16, 8, 4, 2, 1), one per clock.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : shift_sequencer_if.slave (request + result handshakes, busy)
module shift_sequencer (
    input  logic              clock,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned STAGE_W = 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_acc;
    logic [SHAMT_W-1:0] r_amt;
    logic               r_op;
    logic [STAGE_W-1:0] r_stage;

    logic [1:0]         w_state_nxt;
    logic [DATA_W-1:0]  w_acc_nxt;
    logic [SHAMT_W-1:0] w_amt_nxt;
    logic               w_op_nxt;
    logic [STAGE_W-1:0] w_stage_nxt;

    logic               w_sel;
    logic [DATA_W-1:0]  w_sll;
    logic [DATA_W-1:0]  w_sra;
    logic [DATA_W-1:0]  w_shifted;

    // One stage of the shifter: fixed distance chosen by r_stage, enabled by the matching amount bit
    always_comb begin
        w_sel = 1'b0;
        w_sll = r_acc;
        w_sra = r_acc;
        case (r_stage)
            3'd4: begin
                w_sel = r_amt[4];
                w_sll = {r_acc[15:0], 16'h0000};
                w_sra = {{16{r_acc[31]}}, r_acc[31:16]};
            end
            3'd3: begin
                w_sel = r_amt[3];
                w_sll = {r_acc[23:0], 8'h00};
                w_sra = {{8{r_acc[31]}}, r_acc[31:8]};
            end
            3'd2: begin
                w_sel = r_amt[2];
                w_sll = {r_acc[27:0], 4'h0};
                w_sra = {{4{r_acc[31]}}, r_acc[31:4]};
            end
            3'd1: begin
                w_sel = r_amt[1];
                w_sll = {r_acc[29:0], 2'b00};
                w_sra = {{2{r_acc[31]}}, r_acc[31:2]};
            end
            3'd0: begin
                w_sel = r_amt[0];
                w_sll = {r_acc[30:0], 1'b0};
                w_sra = {r_acc[31], r_acc[31:1]};
            end
            default: begin
                w_sel = 1'b0;
            end
        endcase
        w_shifted = !w_sel ? r_acc : (r_op ? w_sra : w_sll);
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_amt_nxt   = r_amt;
        w_op_nxt    = r_op;
        w_stage_nxt = r_stage;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_acc_nxt   = bus.in_data;
                    w_amt_nxt   = bus.in_shamt;
                    w_op_nxt    = bus.in_op;
                    w_stage_nxt = 3'd4;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_acc_nxt = w_shifted;
                if (r_stage == 3'd0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_stage_nxt = r_stage - 3'd1;
                end
            end
            S_DONE: begin
                // acc is held so out_data keeps the last result after the handshake
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_amt   <= '0;
            r_op    <= 1'b0;
            r_stage <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_amt   <= w_amt_nxt;
            r_op    <= w_op_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    // Handshake flags are pure state decodes; out_data comes straight from the accumulator
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
    assign bus.out_data  = r_acc;
endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases, backpressure,
// mid-operation reset and back-to-back traffic, checked through a scoreboard.
module tb_shift_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    shift_sequencer_if bus();

    shift_sequencer u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_cmp   = 0;
    int   n_err   = 0;
    logic prev_ov = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] d, input logic [4:0] s);
        if (op) return 32'($signed(d) >>> s);
        return d << s;
    endfunction

    // Monitor: sampled on the falling edge, looking at handshakes the next rising edge will take
    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && !prev_ov) begin
                if (sb_q.size() == 0) check("spurious_valid", 32'(bus.out_valid), 32'd0);
                else check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'd5);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_result", 32'(bus.out_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("result", bus.out_data, e.data);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back('{ref_shift(bus.in_op, bus.in_data, bus.in_shamt), cyc + 1});
            end
        end
        prev_ov = bus.out_valid;
    end

    task automatic wait_idle();
        int n = 0;
        while (!bus.in_ready && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        check("idle_wait", 32'(bus.in_ready), 32'd1);
    endtask

    // Presents one request; returns #1 after the acceptance edge
    task automatic send(input logic op, input logic [31:0] d, input logic [4:0] s);
        wait_idle();
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_data  = d;
        bus.in_shamt = s;
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    logic        t_op  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_data[6] = '{32'h80000000, 32'h00000001, 32'hDEADBEEF,
                               32'h7FFFFFFF, 32'hF0000000, 32'h12345678};
    logic [4:0]  t_amt [6] = '{5'd8, 5'd31, 5'd0, 5'd31, 5'd31, 5'd4};

    initial begin
        logic [31:0] bp_exp;
        int          n;
        int          last;
        logic        rdy;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shamt  = '0;
        bus.in_op     = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  bus.out_data,       32'd0);
        check("rst_busy",      32'(bus.busy),      32'd0);

        // Directed cases, one at a time
        for (int i = 0; i < 6; i++) begin
            send(t_op[i], t_data[i], t_amt[i]);
            check("busy_after_accept",  32'(bus.busy),     32'd1);
            check("ready_after_accept", 32'(bus.in_ready), 32'd0);
            wait_idle();
        end

        // Backpressure: result held, new request ignored
        bus.out_ready = 1'b0;
        bp_exp = 32'h0ABCD000;
        send(1'b0, 32'h0000ABCD, 5'd12);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        check("bp_valid_rise", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = 1'b1;
        bus.in_data  = 32'hFFFFFFFF;
        bus.in_shamt = 5'd3;
        repeat (10) begin
            @(posedge clock); #1;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_data",  bus.out_data,       bp_exp);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_data_kept",     bus.out_data,       bp_exp);

        // Reset on the edge after T2 abandons the operation
        send(1'b1, 32'h80000000, 5'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_out_data",  bus.out_data,       32'd0);
        check("mid_rst_busy",      32'(bus.busy),      32'd0);
        send(1'b1, 32'hC0000001, 5'd1);
        wait_idle();

        // Back-to-back with in_valid and out_ready held high
        last = 0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.in_op    = 1'($urandom_range(0, 1));
            bus.in_data  = $urandom();
            bus.in_shamt = 5'($urandom_range(0, 31));
            n = 0;
            do begin
                rdy = bus.in_ready;
                @(posedge clock); #1;
                n++;
            end while (!rdy && n < 40);
            check("b2b_accept", 32'(rdy), 32'd1);
            if (k > 0) check("b2b_spacing", 32'(cyc - last), 32'd7);
            last = cyc;
        end
        bus.in_valid = 1'b0;
        wait_idle();
        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule
